// File: rtl/shared_timer_pkg.sv
// Shared constants for the shared interval timer and its round-robin arbiter.
package shared_timer_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int NREQ_MAX = 8;
    // Pointer is sized for the largest supported requester count.
    localparam int PTR_W    = $clog2(NREQ_MAX);

endpackage

// File: rtl/shared_timer_arb_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
    import shared_timer_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant_next
);

    logic [NREQ-1:0] w_rot;
    logic [NREQ-1:0] w_pick;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    assign w_rot      = NREQ'({req, req} >> ptr);
    assign w_pick     = w_rot & (-w_rot);
    assign grant_next = NREQ'(({w_pick, w_pick} << ptr) >> NREQ);

endmodule

// File: rtl/shared_timer_arb.sv
// One interval counter shared by NREQ requesters through a round-robin grant.
// Define SHARED_TIMER_ABORT_EN to end a run early when the owner drops req.
module shared_timer_arb
    import shared_timer_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] dur,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic [WIDTH-1:0]      count
);

    logic [1:0]       r_state, w_state_next;
    logic [NREQ-1:0]  r_grant, w_grant_next;
    logic [NREQ-1:0]  r_done, w_done_next;
    logic             r_busy, w_busy_next;
    logic [WIDTH-1:0] r_count, w_count_next;
    logic [WIDTH-1:0] r_dur_q, w_dur_q_next;
    logic [PTR_W-1:0] r_ptr, w_ptr_next;

    logic [NREQ-1:0]  w_arb_grant;
    logic [WIDTH-1:0] w_dur_arr [NREQ];
    logic [WIDTH-1:0] w_dur_sel;
    logic [PTR_W-1:0] w_owner;
    logic [PTR_W-1:0] w_ptr_adv;
    logic             w_abort;
    logic             w_complete;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req        (req),
        .ptr        (r_ptr),
        .grant_next (w_arb_grant)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_dur
            assign w_dur_arr[gi] = dur[gi*WIDTH +: WIDTH];
        end
    endgenerate

    always_comb begin
        w_dur_sel = '0;
        w_owner   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_arb_grant[i]) w_dur_sel = w_dur_arr[i];
            if (r_grant[i])     w_owner   = PTR_W'(i);
        end
    end

    assign w_ptr_adv  = (w_owner == PTR_W'(NREQ - 1)) ? '0 : w_owner + PTR_W'(1);
    assign w_complete = (r_state == ST_RUN) && tick && (r_count >= r_dur_q);

`ifdef SHARED_TIMER_ABORT_EN
    assign w_abort = (r_state == ST_RUN) && ((r_grant & req) == '0);
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_count <= '0;
            r_dur_q <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_done  <= w_done_next;
            r_busy  <= w_busy_next;
            r_count <= w_count_next;
            r_dur_q <= w_dur_q_next;
            r_ptr   <= w_ptr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (req != '0) w_state_next = ST_RUN;
            ST_RUN: begin
                if (w_abort)         w_state_next = ST_IDLE;
                else if (w_complete) w_state_next = ST_DONE;
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered, so this block computes their values for the next cycle.
    always_comb begin
        w_grant_next = r_grant;
        w_done_next  = '0;
        w_busy_next  = r_busy;
        w_count_next = r_count;
        w_dur_q_next = r_dur_q;
        w_ptr_next   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (req != '0) begin
                    w_grant_next = w_arb_grant;
                    w_dur_q_next = w_dur_sel;
                    w_count_next = '0;
                    w_busy_next  = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_abort) begin
                    w_grant_next = '0;
                    w_count_next = '0;
                    w_busy_next  = 1'b0;
                    w_ptr_next   = w_ptr_adv;
                end else if (w_complete) begin
                    w_done_next  = r_grant;
                    w_grant_next = '0;
                    w_count_next = '0;
                    w_ptr_next   = w_ptr_adv;
                end else if (tick) begin
                    w_count_next = r_count + WIDTH'(1);
                end
            end
            ST_DONE: begin
                w_busy_next  = 1'b0;
                w_grant_next = '0;
                w_count_next = '0;
            end
            default: begin
                w_grant_next = '0;
                w_busy_next  = 1'b0;
                w_count_next = '0;
            end
        endcase
    end

    assign grant = r_grant;
    assign done  = r_done;
    assign busy  = r_busy;
    assign count = r_count;

endmodule
